// File: rtl/std_down_timer.sv
// Programmable down-counting timer with prescaler, one-shot/periodic modes,
// a single-cycle expire pulse and sticky pending/missed flags.
module std_down_timer #(
  parameter int WIDTH     = 16,
  parameter int PRE_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_stop,
  input  logic [WIDTH-1:0]     i_load_value,
  input  logic [PRE_WIDTH-1:0] i_prescale,
  input  logic                 i_periodic,
  input  logic                 i_ack,
  output logic                 o_busy,
  output logic [WIDTH-1:0]     o_count,
  output logic                 o_expire,
  output logic                 o_pending,
  output logic                 o_missed
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [WIDTH-1:0]     CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PRE_WIDTH-1:0] PRE_ONE = {{(PRE_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]           state_q,    state_d;
  logic [WIDTH-1:0]     count_q,    count_d;
  logic [WIDTH-1:0]     load_q,     load_d;
  logic [PRE_WIDTH-1:0] pre_cnt_q,  pre_cnt_d;
  logic [PRE_WIDTH-1:0] pre_q,      pre_d;
  logic                 periodic_q, periodic_d;
  logic                 expire_q,   expire_d;
  logic                 pending_q,  pending_d;
  logic                 missed_q,   missed_d;

  logic tick;
  logic fire;

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    count_d    = count_q;
    load_d     = load_q;
    pre_cnt_d  = pre_cnt_q;
    pre_d      = pre_q;
    periodic_d = periodic_q;
    pending_d  = pending_q;
    missed_d   = missed_q;

    tick = (state_q == ST_RUN) && (pre_cnt_q == pre_q);
    // A stop aborts the period, so it also suppresses the expire it would complete.
    fire     = tick && (count_q == '0) && !i_stop;
    expire_d = fire;

    // A new expire outranks a same-edge acknowledge.
    if (fire) begin
      pending_d = 1'b1;
      missed_d  = i_ack ? 1'b0 : (missed_q | pending_q);
    end else if (i_ack) begin
      pending_d = 1'b0;
      missed_d  = 1'b0;
    end

    if (i_stop) begin
      state_d   = ST_IDLE;
      pre_cnt_d = '0;
    end else if (i_start) begin
      state_d    = ST_RUN;
      count_d    = i_load_value;
      load_d     = i_load_value;
      pre_d      = i_prescale;
      periodic_d = i_periodic;
      pre_cnt_d  = '0;
    end else if (state_q == ST_RUN) begin
      if (tick) begin
        pre_cnt_d = '0;
        if (count_q == '0) begin
          if (periodic_q) begin
            count_d = load_q;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_ONE;
      end
    end
  end

  // NOTE: reset is synchronous and clears every flop, latched configuration included.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      load_q     <= '0;
      pre_cnt_q  <= '0;
      pre_q      <= '0;
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
      pending_q  <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q    <= state_d;
      count_q    <= count_d;
      load_q     <= load_d;
      pre_cnt_q  <= pre_cnt_d;
      pre_q      <= pre_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
      pending_q  <= pending_d;
      missed_q   <= missed_d;
    end
  end

  assign o_busy    = (state_q == ST_RUN);
  assign o_count   = count_q;
  assign o_expire  = expire_q;
  assign o_pending = pending_q;
  assign o_missed  = missed_q;

endmodule

// File: tb/tb_std_down_timer.sv
// Self-checking bench for std_down_timer: a vector table, directed corner
// sequences and a randomized run against an elapsed-time reference model.
module tb_std_down_timer;

  localparam int WIDTH     = 16;
  localparam int PRE_WIDTH = 8;

  logic                 clk = 1'b0;
  logic                 rst, start, stop, periodic, ack;
  logic [WIDTH-1:0]     load_value;
  logic [PRE_WIDTH-1:0] prescale;
  logic                 o_busy, o_expire, o_pending, o_missed;
  logic [WIDTH-1:0]     o_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  std_down_timer #(.WIDTH(WIDTH), .PRE_WIDTH(PRE_WIDTH)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_stop      (stop),
    .i_load_value(load_value),
    .i_prescale  (prescale),
    .i_periodic  (periodic),
    .i_ack       (ack),
    .o_busy      (o_busy),
    .o_count     (o_count),
    .o_expire    (o_expire),
    .o_pending   (o_pending),
    .o_missed    (o_missed)
  );

  typedef struct {
    logic                 rst, start, stop;
    logic [WIDTH-1:0]     load;
    logic [PRE_WIDTH-1:0] pre;
    logic                 periodic, ack;
    logic                 busy;
    logic [WIDTH-1:0]     count;
    logic                 expire, pending, missed;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; start = 1'b0; stop = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_start(input logic [WIDTH-1:0] l, input logic [PRE_WIDTH-1:0] p, input logic per);
    load_value = l; prescale = p; periodic = per; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic check_all(input string name, input logic b, input logic [WIDTH-1:0] c,
                           input logic e, input logic pd, input logic m);
    check(name, {o_busy, o_count, o_expire, o_pending, o_missed}, {b, c, e, pd, m});
  endtask

  // Reference model: tracks clocks elapsed in the current period and derives
  // the count from it arithmetically.
  logic   m_run, m_per, m_exp, m_pend, m_miss;
  longint m_l, m_p, m_el, m_count;

  task automatic model_edge();
    longint period;
    logic   fire;
    if (rst) begin
      m_run = 0; m_per = 0; m_exp = 0; m_pend = 0; m_miss = 0;
      m_l = 0; m_p = 0; m_el = 0; m_count = 0;
      return;
    end
    period = (m_l + 1) * (m_p + 1);
    fire   = m_run && !stop && (m_el + 1 == period);
    m_exp  = fire;
    if (fire) begin
      m_miss = ack ? 1'b0 : (m_miss | m_pend);
      m_pend = 1'b1;
    end else if (ack) begin
      m_pend = 1'b0;
      m_miss = 1'b0;
    end
    if (stop) begin
      m_run = 1'b0;
    end else if (start) begin
      m_run = 1'b1; m_el = 0; m_l = longint'(load_value); m_p = longint'(prescale);
      m_per = periodic; m_count = m_l;
    end else if (m_run) begin
      m_el++;
      if (fire) begin
        if (m_per) begin m_el = 0; m_count = m_l; end
        else begin m_run = 1'b0; m_count = 0; end
      end else begin
        m_count = m_l - m_el / (m_p + 1);
      end
    end
  endtask

  initial begin
    logic early;
    idle_inputs();
    load_value = '0; prescale = '0; periodic = 1'b0;

    // Table: reset, one-shot L=3 P=0 countdown, ack, reset beats start.
    vecs[0] = '{1, 0, 0, 16'd0, 8'd0, 0, 0,   0, 16'd0, 0, 0, 0};
    vecs[1] = '{0, 1, 0, 16'd3, 8'd0, 0, 0,   1, 16'd3, 0, 0, 0};
    vecs[2] = '{0, 0, 0, 16'd9, 8'd4, 1, 0,   1, 16'd2, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 16'd9, 8'd4, 1, 0,   1, 16'd1, 0, 0, 0};
    vecs[4] = '{0, 0, 0, 16'd0, 8'd0, 0, 0,   1, 16'd0, 0, 0, 0};
    vecs[5] = '{0, 0, 0, 16'd0, 8'd0, 0, 0,   0, 16'd0, 1, 1, 0};
    vecs[6] = '{0, 0, 0, 16'd0, 8'd0, 0, 0,   0, 16'd0, 0, 1, 0};
    vecs[7] = '{0, 0, 0, 16'd0, 8'd0, 0, 1,   0, 16'd0, 0, 0, 0};
    vecs[8] = '{1, 1, 0, 16'd7, 8'd3, 1, 0,   0, 16'd0, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
      load_value = vecs[i].load; prescale = vecs[i].pre;
      periodic = vecs[i].periodic; ack = vecs[i].ack;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].busy, vecs[i].count,
                vecs[i].expire, vecs[i].pending, vecs[i].missed);
    end
    idle_inputs();

    // Periodic L=2 P=1: expires every 6 clocks, missed after 2nd unacked expire.
    do_reset();
    do_start(16'd2, 8'd1, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      step();
      check($sformatf("t2 expire k%0d", k), o_expire, (k % 6) == 0);
      if (k == 1)  check("t2 count k1", o_count, 2);
      if (k == 2)  check("t2 count k2", o_count, 1);
      if (k == 6)  check("t2 flags k6", {o_pending, o_missed, o_busy, o_count}, {3'b101, 16'd2});
      if (k == 12) check("t2 flags k12", {o_pending, o_missed}, 2'b11);
    end

    // Periodic L=1 P=0, ack on the edge of the 2nd expire.
    do_reset();
    do_start(16'd1, 8'd0, 1'b1);
    step(); step();
    check("t3 first expire", {o_expire, o_pending, o_missed}, 3'b110);
    step();
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("t3 ack vs expire", {o_expire, o_pending, o_missed}, 3'b110);
    step(); step();
    check("t3 third expire", {o_expire, o_pending, o_missed}, 3'b111);

    // Stop after 3 clocks of counting from L=5.
    do_reset();
    do_start(16'd5, 8'd0, 1'b0);
    step(); step(); step();
    check("t4 count before stop", o_count, 2);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check_all("t4 after stop", 0, 16'd2, 0, 0, 0);
    early = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (o_expire || o_count != 16'd2) early = 1'b1;
    end
    check("t4 held idle", early, 0);

    // Start+stop together stays idle; L=0 P=0 expires on the first tick.
    do_reset();
    stop = 1'b1;
    do_start(16'd4, 8'd0, 1'b0);
    stop = 1'b0;
    check_all("t5 start+stop", 0, 16'd0, 0, 0, 0);
    do_start(16'd0, 8'd0, 1'b0);
    check_all("t5 L0 started", 1, 16'd0, 0, 0, 0);
    step();
    check_all("t5 L0 expire", 0, 16'd0, 1, 1, 0);

    // Reset mid-run, then the maximum load value.
    do_reset();
    do_start(16'd3, 8'd2, 1'b1);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all("t6 reset mid-run", 0, 16'd0, 0, 0, 0);
    early = 1'b0;
    repeat (15) begin
      step();
      if (o_expire || o_busy) early = 1'b1;
    end
    check("t6 quiet after reset", early, 0);
    do_start(16'hFFFF, 8'd0, 1'b0);
    early = 1'b0;
    for (int k = 1; k <= 65535; k++) begin
      step();
      if (o_expire) early = 1'b1;
      if (k == 1) check("t6 count k1", o_count, 16'hFFFE);
    end
    check("t6 no early expire", {early, o_count, o_busy}, {1'b0, 16'd0, 1'b1});
    step();
    check_all("t6 max expire", 0, 16'd0, 1, 1, 0);

    // Restart on the same edge as an expire tick.
    do_reset();
    do_start(16'd1, 8'd0, 1'b1);
    step();
    load_value = 16'd3; prescale = 8'd0; periodic = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    check_all("t7 restart on expire", 1, 16'd3, 1, 1, 0);

    // Randomized run against the reference model.
    rst = 1'b1;
    step();
    model_edge();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom % 200) == 0;
      start      = ($urandom % 12) == 0;
      stop       = ($urandom % 25) == 0;
      ack        = ($urandom % 6) == 0;
      load_value = WIDTH'($urandom % 6);
      prescale   = PRE_WIDTH'($urandom % 3);
      periodic   = 1'($urandom % 2);
      step();
      model_edge();
      check($sformatf("rand c%0d", c), {o_busy, o_count, o_expire, o_pending, o_missed},
            {m_run, m_count[WIDTH-1:0], m_exp, m_pend, m_miss});
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
